pid_math_mc: RTL
================

# pid_math_mc

Multi-channel, parametrised successor to the single-axis PD math block in the flight controller. It time-multiplexes one saturating error datapath across NUM_CH axes (roll/pitch/yaw by default), tagging each sample with a channel number. Each channel keeps its own derivative history queue and a new saturating, clearable integrator, and the block returns P, I and D terms with a valid strobe. It sits between the sensor-fusion outputs and the flight-control mixer.

## Interface
- NUM_CH, 3, number of independent channels; CH_W = max(1, $clog2(NUM_CH))
- ERR_W, 10, saturated error width (signed)
- D_DEPTH, 12, derivative history depth in samples, per channel, ≥1
- D_SAT_W, 7, saturated derivative-difference width (signed)
- DGAIN, 7, derivative gain, signed 5-bit constant; DTERM_W = D_SAT_W+5
- I_W, 16, integrator accumulator width (signed)
- I_SHIFT, 6, integrator right shift to form iterm; ITERM_W = I_W-I_SHIFT
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- vld  in  1  sample strobe; ch/desired/actual sampled when high
- ch  in  CH_W  channel of the current sample
- desired  in  16  signed setpoint
- actual  in  16  signed measurement
- int_en  in  1  integrator update enable, sampled with vld
- clr_int  in  1  synchronous clear of all integrators
- out_vld  out  1  one-cycle strobe: pterm/iterm/dterm/out_ch valid
- out_ch  out  CH_W  channel of the presented result
- pterm  out  ERR_W  signed 5/8·err
- iterm  out  ITERM_W  signed integrator >>> I_SHIFT
- dterm  out  DTERM_W  signed DGAIN·D_diff_sat

## Operation
- Stage 0 (comb): err = sign-extended actual − desired (17 bits); saturate to ERR_W signed: [−2^(ERR_W−1), 2^(ERR_W−1)−1].
- Stage 1 (reg, on vld with ch < NUM_CH): err_q, ch_q, int_en_q, v1 ← 1; otherwise v1 ← 0. ch ≥ NUM_CH: sample dropped, no state change, no out_vld.
- Stage 2 (reg, on v1):
  - pterm = (err_q >>> 1) + (err_q >>> 3), ERR_W bits, arithmetic shifts.
  - D_diff = err_q − q[ch_q][D_DEPTH−1], computed at ERR_W+1 bits (no wrap); saturate to D_SAT_W signed; dterm = DGAIN × D_diff_sat, signed, DTERM_W.
  - q[ch_q] shifts one place; q[ch_q][0] ← err_q. Other channels' queues untouched.
  - If int_en_q: acc[ch_q] ← sat_I_W(acc[ch_q] + sext(err_q)); else acc unchanged. iterm = (new acc) >>> I_SHIFT.
  - out_ch ← ch_q, out_vld ← 1. Without v1: out_vld ← 0; pterm/iterm/dterm/out_ch hold.
- clr_int: sets all acc to 0 at the next edge; takes priority over a simultaneous update (the result presented uses acc = 0, i.e. iterm = 0).
- Queue entries and accumulators start at 0: the first D_DEPTH samples of a channel difference against 0.

## Timing
- Reset: all outputs, v1, pipeline registers, all queue entries and accumulators = 0.
- Latency: vld sampled at edge N → out_vld high after edge N+2, for exactly one cycle per accepted sample.
- Throughput: one sample per cycle, any channel order. Back-to-back same-channel samples must see the queue/accumulator state written by the preceding sample (write at edge N+2, read for the following sample before edge N+3); no stall, no hazard.
- rst_n asserted mid-pipeline: in-flight samples are discarded and no out_vld is produced for them.
- No handshake back-pressure: the consumer must accept every out_vld.

## Test plan
- Reset, then ch0 desired=0 actual=100 for one vld → 2 cycles later out_vld=1, out_ch=0, pterm=62, dterm=441 (D_diff 100 saturates to 63), iterm=1 (acc=100, with int_en=1).
- Saturation: actual=16'h7FFF desired=16'h8000 → pterm=318, dterm=441. Then, on a fresh channel, actual=16'h8000 desired=16'h7FFF → err=−512, pterm=−320 (10'h2C0), dterm=−448.
- Depth/isolation: 13 ch1 samples with err=20, interleaved with ch0 samples err=0 → ch1 dterm=140 for samples 1–12, then 0 on sample 13; ch0 dterm always 0.
- Integrator clamp: ch2 err=511 with int_en=1 every cycle → acc=32704 after 64 samples, clamps to 32767 on sample 65, iterm=511. Then pulse clr_int with a sample → iterm=0; the next sample gives acc=511.
- int_en=0 holds acc (iterm unchanged). A ch=3 sample produces no out_vld and no state change.
- Assert rst_n low one cycle after vld → no out_vld, and all outputs read 0.

Source files
------------

// File: rtl/pid_math_mc.sv
// pid_math_mc: time-multiplexed multi-channel P/I/D term datapath with per-channel history and integrators
module pid_math_mc #(
    parameter int NUM_CH  = 3,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int ERR_W   = 10,
    parameter int D_DEPTH = 12,
    parameter int D_SAT_W = 7,
    parameter int DGAIN   = 7,
    parameter int I_W     = 16,
    parameter int I_SHIFT = 6,
    parameter int DTERM_W = D_SAT_W + 5,
    parameter int ITERM_W = I_W - I_SHIFT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vld,
    input  logic [CH_W-1:0]           ch,
    input  logic signed [15:0]        desired,
    input  logic signed [15:0]        actual,
    input  logic                      int_en,
    input  logic                      clr_int,
    output logic                      out_vld,
    output logic [CH_W-1:0]           out_ch,
    output logic signed [ERR_W-1:0]   pterm,
    output logic signed [ITERM_W-1:0] iterm,
    output logic signed [DTERM_W-1:0] dterm
);
    localparam logic signed [4:0] DG = 5'(DGAIN);

    logic                      vld_r, ie_r, v1, ie_q;
    logic [CH_W-1:0]           ch_r, ch_q;
    logic signed [15:0]        des_r, act_r;
    logic signed [16:0]        diff;
    logic signed [ERR_W-1:0]   err_s, err_q, p_n, last;
    logic signed [ERR_W:0]     dd;
    logic signed [D_SAT_W-1:0] dsat;
    logic signed [DTERM_W-1:0] d_n;
    logic signed [I_W-1:0]     acc_cur, acc_n;
    logic signed [I_W:0]       sum;
    logic signed [ERR_W-1:0]   q [NUM_CH][D_DEPTH];
    logic signed [I_W-1:0]     acc [NUM_CH];

    // error saturation and stage-2 term arithmetic on the selected channel's state
    always_comb begin
        diff    = {act_r[15], act_r} - {des_r[15], des_r};
        err_s   = (&diff[16:ERR_W-1] || ~|diff[16:ERR_W-1]) ? diff[ERR_W-1:0]
                                                            : {diff[16], {(ERR_W-1){~diff[16]}}};
        last    = q[ch_q][D_DEPTH-1];
        dd      = {err_q[ERR_W-1], err_q} - {last[ERR_W-1], last};
        dsat    = (&dd[ERR_W:D_SAT_W-1] || ~|dd[ERR_W:D_SAT_W-1]) ? dd[D_SAT_W-1:0]
                                                                  : {dd[ERR_W], {(D_SAT_W-1){~dd[ERR_W]}}};
        d_n     = DTERM_W'(dsat) * DTERM_W'(DG);
        p_n     = (err_q >>> 1) + (err_q >>> 3);
        acc_cur = acc[ch_q];
        sum     = {acc_cur[I_W-1], acc_cur} + (I_W+1)'(err_q);
        acc_n   = clr_int ? '0 :
                  !ie_q   ? acc_cur :
                  (sum[I_W] == sum[I_W-1]) ? sum[I_W-1:0] : {sum[I_W], {(I_W-1){~sum[I_W]}}};
    end

    // input capture and stage-1 error register; out-of-range channels are dropped here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= 1'b0;
            ie_r  <= 1'b0;
            ch_r  <= '0;
            des_r <= '0;
            act_r <= '0;
            v1    <= 1'b0;
            ie_q  <= 1'b0;
            ch_q  <= '0;
            err_q <= '0;
        end else begin
            vld_r <= vld;
            ie_r  <= int_en;
            ch_r  <= ch;
            des_r <= desired;
            act_r <= actual;
            v1    <= vld_r && (int'(ch_r) < NUM_CH);
            if (vld_r) begin
                ie_q  <= ie_r;
                ch_q  <= ch_r;
                err_q <= err_s;
            end
        end
    end

    // stage-2 result registers plus per-channel history and integrator update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_ch  <= '0;
            pterm   <= '0;
            iterm   <= '0;
            dterm   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                for (int k = 0; k < D_DEPTH; k++) q[c][k] <= '0;
            end
        end else begin
            out_vld <= v1;
            if (v1) begin
                out_ch     <= ch_q;
                pterm      <= p_n;
                dterm      <= d_n;
                iterm      <= acc_n[I_W-1:I_SHIFT];
                q[ch_q][0] <= err_q;
                for (int k = 1; k < D_DEPTH; k++) q[ch_q][k] <= q[ch_q][k-1];
            end
            if (clr_int) begin
                for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
            end else if (v1) begin
                acc[ch_q] <= acc_n;
            end
        end
    end
endmodule
